ibex_obi_arbiter: RTL and testbench

//  N-host to 1-device arbiter for the Ibex OBI-style req/gnt/rvalid memory bus.

---
 rtl/ibex_obi_arbiter_pkg.sv | 5 +
 rtl/ibex_obi_arbiter_if.sv | 25 ++
 rtl/ibex_obi_arb_id_fifo.sv | 40 ++++
 rtl/ibex_obi_arbiter.sv | 78 +++++++
 tb/tb_ibex_obi_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/ibex_obi_arbiter_pkg.sv
// ibex_obi_arbiter_pkg: shared types and constants for the OBI arbiter
package ibex_obi_arbiter_pkg;
  typedef enum logic {ArbRoundRobin = 1'b0, ArbFixed = 1'b1} arb_mode_e;
  localparam int unsigned IntgWidth = 7;
endpackage

// File: rtl/ibex_obi_arbiter_if.sv
// ibex_obi_arbiter_if: OBI req/gnt/rvalid bundle for NumPorts ports (integrity sideband with IBEX_OBI_ARB_INTG_EN)
interface ibex_obi_arbiter_if #(
  parameter int unsigned NumPorts  = 1,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  logic [NumPorts-1:0]             req;
  logic [NumPorts-1:0]             gnt;
  logic [NumPorts*AddrWidth-1:0]   addr;
  logic [NumPorts-1:0]             we;
  logic [NumPorts*DataWidth/8-1:0] be;
  logic [NumPorts*DataWidth-1:0]   wdata;
  logic [NumPorts-1:0]             rvalid;
  logic [DataWidth-1:0]            rdata;
  logic [NumPorts-1:0]             err;
`ifdef IBEX_OBI_ARB_INTG_EN
  logic [NumPorts*ibex_obi_arbiter_pkg::IntgWidth-1:0] wdata_intg;
  logic [ibex_obi_arbiter_pkg::IntgWidth-1:0]          rdata_intg;
  modport master (output req, addr, we, be, wdata, wdata_intg, input gnt, rvalid, rdata, err, rdata_intg);
  modport slave  (input req, addr, we, be, wdata, wdata_intg, output gnt, rvalid, rdata, err, rdata_intg);
`else
  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
`endif
endinterface

// File: rtl/ibex_obi_arb_id_fifo.sv
// ibex_obi_arb_id_fifo: in-order FIFO of granted host IDs awaiting their response
module ibex_obi_arb_id_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 2,
  localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [Width-1:0]    wdata_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [CntWidth-1:0] count_o,
  output logic [Width-1:0]    head_o
);
  localparam int unsigned PtrWidth = Depth > 1 ? $clog2(Depth) : 1;
  logic [Width-1:0]    mem [Depth];
  logic [PtrWidth-1:0] wr_ptr, rd_ptr;
  logic                do_push, do_pop;
  assign full_o  = count_o == CntWidth'(Depth);
  assign empty_o = count_o == '0;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem[rd_ptr];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata_i;
        wr_ptr      <= (32'(wr_ptr) == Depth - 1) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= (32'(rd_ptr) == Depth - 1) ? '0 : rd_ptr + 1'b1;
      count_o <= count_o + CntWidth'(do_push) - CntWidth'(do_pop);
    end
  end
endmodule

// File: rtl/ibex_obi_arbiter.sv
// ibex_obi_arbiter: N-host to 1-device OBI arbiter with lock, RR/fixed modes and in-order response routing (IBEX_OBI_ARB_INTG_EN adds integrity pass-through)
module ibex_obi_arbiter
  import ibex_obi_arbiter_pkg::*;
#(
  parameter int unsigned NumHosts       = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2,
  parameter arb_mode_e   ArbMode        = ArbRoundRobin,
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ibex_obi_arbiter_if.slave   host,
  ibex_obi_arbiter_if.master  dev,
  output logic [CntWidth-1:0] outstanding_o,
  output logic                idle_o,
  output logic                unexp_rsp_o
);
  localparam int unsigned IdWidth = $clog2(NumHosts);
  localparam int unsigned BeWidth = DataWidth / 8;
  logic [IdWidth-1:0]  rr_ptr, lock_id, cand, pick, sel, head;
  logic                lock_valid, full, empty, accept, pop;
  logic [NumHosts-1:0] rsp;
  always_comb begin
    cand = '0;
    pick = '0;
    for (int k = NumHosts - 1; k >= 0; k--) begin
      cand = IdWidth'((k + ((ArbMode == ArbFixed) ? 0 : int'(rr_ptr))) % NumHosts);
      if (host.req[cand]) pick = cand;
    end
  end
  assign sel         = lock_valid ? lock_id : pick;
  assign dev.req     = host.req[sel] & ~full;
  assign accept      = dev.req[0] & dev.gnt[0];
  assign host.gnt    = accept ? NumHosts'(1) << sel : '0;
  assign dev.addr    = host.addr[32'(sel)*AddrWidth +: AddrWidth];
  assign dev.we      = host.we[sel];
  assign dev.be      = host.be[32'(sel)*BeWidth +: BeWidth];
  assign dev.wdata   = host.wdata[32'(sel)*DataWidth +: DataWidth];
  assign pop         = dev.rvalid[0] & ~empty;
  assign rsp         = pop ? NumHosts'(1) << head : '0;
  assign host.rvalid = rsp;
  assign host.err    = dev.err[0] ? rsp : '0;
  assign host.rdata  = dev.rdata;
  assign idle_o      = ~|host.req & empty;
`ifdef IBEX_OBI_ARB_INTG_EN
  assign dev.wdata_intg  = host.wdata_intg[32'(sel)*IntgWidth +: IntgWidth];
  assign host.rdata_intg = dev.rdata_intg;
`endif
  ibex_obi_arb_id_fifo #(
    .Width(IdWidth),
    .Depth(MaxOutstanding)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (accept),
    .pop_i  (pop),
    .wdata_i(sel),
    .full_o (full),
    .empty_o(empty),
    .count_o(outstanding_o),
    .head_o (head)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr      <= '0;
      lock_valid  <= 1'b0;
      lock_id     <= '0;
      unexp_rsp_o <= 1'b0;
    end else begin
      lock_valid <= dev.req[0] & ~dev.gnt[0];
      lock_id    <= sel;
      if (accept && ArbMode == ArbRoundRobin) rr_ptr <= (32'(sel) == NumHosts - 1) ? '0 : sel + 1'b1;
      if (dev.rvalid[0] && empty) unexp_rsp_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ibex_obi_arbiter.sv
// tb_ibex_obi_arbiter: checks RR and fixed-priority arbiters against a queue model plus literal expectations
module tb_ibex_obi_arbiter;
  import ibex_obi_arbiter_pkg::*;
  logic        clk = 1'b0, rst = 1'b1, rst_nx = 1'b1, chk_en = 1'b0;
  logic [1:0]  req = '0, we = 2'b10;
  logic [63:0] addr = {32'h0000_2000, 32'h0000_1000};
  logic [7:0]  be = 8'hc3;
  logic [63:0] wdata = {32'hbbbb_0001, 32'haaaa_0000};
  logic        dgnt = 1'b0, drv = 1'b0, derr = 1'b0;
  logic [31:0] drdata = '0;
  int          n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  ibex_obi_arbiter_if #(.NumPorts(2)) h_rr ();
  ibex_obi_arbiter_if #(.NumPorts(1)) d_rr ();
  ibex_obi_arbiter_if #(.NumPorts(2)) h_fx ();
  ibex_obi_arbiter_if #(.NumPorts(1)) d_fx ();
  assign h_rr.req = req;   assign h_fx.req = req;
  assign h_rr.addr = addr; assign h_fx.addr = addr;
  assign h_rr.we = we;     assign h_fx.we = we;
  assign h_rr.be = be;     assign h_fx.be = be;
  assign h_rr.wdata = wdata; assign h_fx.wdata = wdata;
  assign d_rr.gnt = dgnt;  assign d_fx.gnt = dgnt;
  assign d_rr.rvalid = drv; assign d_fx.rvalid = drv;
  assign d_rr.err = derr;  assign d_fx.err = derr;
  assign d_rr.rdata = drdata; assign d_fx.rdata = drdata;
`ifdef IBEX_OBI_ARB_INTG_EN
  assign h_rr.wdata_intg = '0; assign h_fx.wdata_intg = '0;
  assign d_rr.rdata_intg = '0; assign d_fx.rdata_intg = '0;
`endif
  logic [1:0]  out [2];
  logic        idle [2], unx [2];
  ibex_obi_arbiter #(.ArbMode(ArbRoundRobin)) u_rr (
    .clk_i(clk), .rst_i(rst), .host(h_rr), .dev(d_rr),
    .outstanding_o(out[0]), .idle_o(idle[0]), .unexp_rsp_o(unx[0])
  );
  ibex_obi_arbiter #(.ArbMode(ArbFixed)) u_fx (
    .clk_i(clk), .rst_i(rst), .host(h_fx), .dev(d_fx),
    .outstanding_o(out[1]), .idle_o(idle[1]), .unexp_rsp_o(unx[1])
  );
  logic [1:0]  a_gnt [2], a_rv [2], a_err [2];
  logic        a_dreq [2], a_we [2];
  logic [31:0] a_addr [2], a_wdata [2], a_rdata [2];
  logic [3:0]  a_be [2];
  assign a_gnt[0] = h_rr.gnt;    assign a_gnt[1] = h_fx.gnt;
  assign a_rv[0] = h_rr.rvalid;  assign a_rv[1] = h_fx.rvalid;
  assign a_err[0] = h_rr.err;    assign a_err[1] = h_fx.err;
  assign a_rdata[0] = h_rr.rdata; assign a_rdata[1] = h_fx.rdata;
  assign a_dreq[0] = d_rr.req[0]; assign a_dreq[1] = d_fx.req[0];
  assign a_we[0] = d_rr.we[0];   assign a_we[1] = d_fx.we[0];
  assign a_addr[0] = d_rr.addr;  assign a_addr[1] = d_fx.addr;
  assign a_wdata[0] = d_rr.wdata; assign a_wdata[1] = d_fx.wdata;
  assign a_be[0] = d_rr.be;      assign a_be[1] = d_fx.be;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // model: instance 0 round-robin, 1 fixed; FIFO kept as a shifting list
  int         m_cnt [2] = '{0, 0}, m_rr [2] = '{0, 0}, m_lkid [2] = '{0, 0};
  int         m_ids [2][4];
  bit         m_lk [2] = '{0, 0}, m_unx [2] = '{0, 0};
  int         win, h;
  bit         dreq, acc, pop;
  logic [1:0] erv;
  string      p;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        p = m ? "fx" : "rr";
        win = -1;
        if (m_lk[m]) win = m_lkid[m];
        else
          for (int k = 1; k >= 0; k--) begin
            h = (m == 1) ? k : (m_rr[m] + k) % 2;
            if (req[h]) win = h;
          end
        dreq = (win >= 0) ? (req[win] && m_cnt[m] < 2) : 1'b0;
        acc = dreq && dgnt;
        pop = drv && m_cnt[m] > 0;
        erv = pop ? 2'(1 << m_ids[m][0]) : 2'b00;
        chk({p, ".dev_req"}, 64'(a_dreq[m]), 64'(dreq));
        chk({p, ".gnt"}, 64'(a_gnt[m]), acc ? 64'(1 << win) : 64'd0);
        chk({p, ".rvalid"}, 64'(a_rv[m]), 64'(erv));
        chk({p, ".err"}, 64'(a_err[m]), derr ? 64'(erv) : 64'd0);
        chk({p, ".outstanding"}, 64'(out[m]), 64'(m_cnt[m]));
        chk({p, ".idle"}, 64'(idle[m]), 64'(req == 2'b00 && m_cnt[m] == 0));
        chk({p, ".unexp"}, 64'(unx[m]), 64'(m_unx[m]));
        chk({p, ".rdata"}, 64'(a_rdata[m]), 64'(drdata));
        if (dreq) begin
          chk({p, ".addr"}, 64'(a_addr[m]), 64'(addr[win*32 +: 32]));
          chk({p, ".we"}, 64'(a_we[m]), 64'(we[win]));
          chk({p, ".be"}, 64'(a_be[m]), 64'(be[win*4 +: 4]));
          chk({p, ".wdata"}, 64'(a_wdata[m]), 64'(wdata[win*32 +: 32]));
        end
        if (rst) begin
          m_cnt[m] = 0; m_rr[m] = 0; m_lk[m] = 0; m_lkid[m] = 0; m_unx[m] = 0;
        end else begin
          if (drv && m_cnt[m] == 0) m_unx[m] = 1;
          if (pop) begin
            for (int i = 0; i < 3; i++) m_ids[m][i] = m_ids[m][i+1];
            m_cnt[m]--;
          end
          if (acc) begin
            m_ids[m][m_cnt[m]] = win;
            m_cnt[m]++;
            if (m == 0) m_rr[m] = (win + 1) % 2;
          end
          m_lk[m] = dreq && !dgnt;
          m_lkid[m] = win;
        end
      end
    end
  end
  task automatic step(input logic [1:0] r, input logic g, input logic v, input logic e);
    @(posedge clk);
    #1;
    rst = rst_nx; req = r; dgnt = g; drv = v; derr = e; drdata = $urandom;
    @(negedge clk);
  endtask
  initial begin
    @(posedge clk);
    #1 chk_en = 1'b1;
    step(2'b00, 0, 0, 0);
    chk("rst.outstanding", 64'(out[0]), 64'd0);
    chk("rst.idle", 64'(idle[1]), 64'd1);
    chk("rst.dev_req", 64'(a_dreq[0]), 64'd0);
    chk("rst.gnt", 64'(a_gnt[1]), 64'd0);
    chk("rst.unexp", 64'(unx[0]), 64'd0);
    rst_nx = 1'b0;
    step(2'b11, 1, 0, 0);
    chk("t1.gnt_c1", 64'(a_gnt[0]), 64'b01);
    chk("t1.rv_c1", 64'(a_rv[0]), 64'b00);
    step(2'b11, 1, 1, 0);
    chk("t1.gnt_c2", 64'(a_gnt[0]), 64'b10);
    chk("t1.rv_c2", 64'(a_rv[0]), 64'b01);
    chk("t1.addr_c2", 64'(a_addr[0]), 64'h2000);
    step(2'b11, 1, 1, 0);
    chk("t1.gnt_c3", 64'(a_gnt[0]), 64'b01);
    chk("t1.rv_c3", 64'(a_rv[0]), 64'b10);
    step(2'b11, 1, 1, 0);
    chk("t1.gnt_c4", 64'(a_gnt[0]), 64'b10);
    chk("t1.rv_c4", 64'(a_rv[0]), 64'b01);
    step(2'b00, 0, 1, 0);
    chk("t1.rv_c5", 64'(a_rv[0]), 64'b10);
    step(2'b10, 0, 0, 0);
    chk("t2.dev_req", 64'(a_dreq[1]), 64'd1);
    step(2'b11, 0, 0, 0);
    chk("t2.locked_addr", 64'(a_addr[1]), 64'h2000);
    step(2'b11, 0, 0, 0);
    step(2'b11, 1, 0, 0);
    chk("t2.gnt_first", 64'(a_gnt[1]), 64'b10);
    step(2'b01, 1, 0, 0);
    chk("t2.gnt_second", 64'(a_gnt[1]), 64'b01);
    step(2'b00, 0, 1, 0);
    chk("t2.rv_first", 64'(a_rv[1]), 64'b10);
    step(2'b00, 0, 1, 0);
    chk("t2.rv_second", 64'(a_rv[1]), 64'b01);
    step(2'b11, 1, 0, 0);
    step(2'b11, 1, 0, 0);
    step(2'b11, 1, 0, 0);
    chk("t3.full_req_fx", 64'(a_dreq[1]), 64'd0);
    chk("t3.full_req_rr", 64'(a_dreq[0]), 64'd0);
    chk("t3.full_out", 64'(out[1]), 64'd2);
    step(2'b11, 1, 1, 0);
    chk("t3.req_with_rv", 64'(a_dreq[1]), 64'd0);
    chk("t3.rv", 64'(a_rv[1]), 64'b01);
    step(2'b11, 1, 0, 0);
    chk("t3.req_after_pop", 64'(a_dreq[1]), 64'd1);
    chk("t3.gnt_after_pop", 64'(a_gnt[1]), 64'b01);
    rst_nx = 1'b1;
    step(2'b00, 0, 0, 0);
    chk("t5.pre_rst_out", 64'(out[0]), 64'd2);
    rst_nx = 1'b0;
    step(2'b00, 0, 0, 0);
    chk("t5.out", 64'(out[0]), 64'd0);
    chk("t5.idle", 64'(idle[0]), 64'd1);
    chk("t5.unexp", 64'(unx[1]), 64'd0);
    step(2'b00, 0, 1, 0);
    chk("t4.no_rv_rr", 64'(a_rv[0]), 64'b00);
    chk("t4.no_rv_fx", 64'(a_rv[1]), 64'b00);
    step(2'b00, 0, 0, 0);
    chk("t4.unexp_set", 64'(unx[0]), 64'd1);
    step(2'b00, 0, 0, 0);
    chk("t4.unexp_held", 64'(unx[1]), 64'd1);
    step(2'b10, 1, 0, 0);
    chk("t6.gnt", 64'(a_gnt[0]), 64'b10);
    step(2'b00, 0, 1, 1);
    chk("t6.rv", 64'(a_rv[0]), 64'b10);
    chk("t6.err", 64'(a_err[0]), 64'b10);
    chk("t6.err_fx", 64'(a_err[1]), 64'b10);
    step(2'b00, 0, 0, 0);
    chk("t6.idle", 64'(idle[0]), 64'd1);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
